// File: rtl/snake_pkg.sv
// Shared state codes for the snake game sequencer, display mux and renderer.
package snake_pkg;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_PLAY    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WIN     = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOSE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_PAUSE   = 3'd4;
  localparam logic [STATE_W-1:0] ST_RESPAWN = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_PLAY    = ST_PLAY,
    S_WIN     = ST_WIN,
    S_LOSE    = ST_LOSE,
    S_PAUSE   = ST_PAUSE,
    S_RESPAWN = ST_RESPAWN
  } state_e;
endpackage

// File: rtl/game_flow_controller_edge.sv
// Rising-edge detector; history loads the live input on reset so a
// button held through reset never reads as a press.
module edge_detect #(
  parameter int W = 1
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic [W-1:0] d_i,
  output logic         rise_o
);
  logic [W-1:0] prev_q;

  always_ff @(posedge CLOCK) begin
    prev_q <= d_i;
  end

  assign rise_o = |(d_i & ~prev_q);

  logic unused_rst;
  assign unused_rst = RESET;
endmodule

// File: rtl/game_flow_controller.sv
// Snake game sequencer: idle/play/pause/respawn/win/lose with lives,
// respawn delay and end-screen lockout.
module game_flow_controller
  import snake_pkg::*;
#(
  parameter int WIN_SCORE       = 10,
  parameter int SCORE_W         = 4,
  parameter int BTN_W           = 4,
  parameter int LIVES           = 3,
  parameter int LIVES_W         = 2,
  parameter int RESPAWN_CYCLES  = 25_000_000,
  parameter int END_HOLD_CYCLES = 50_000_000,
  parameter int TIMER_W         = 26
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [BTN_W-1:0]   PUSH_BUTTONS,
  input  logic               PAUSE_BTN,
  input  logic [SCORE_W-1:0] SCORE_IN,
  input  logic               SUICIDE_IN,
  output logic [2:0]         STATE_OUT,
  output logic [LIVES_W-1:0] LIVES_OUT,
  output logic               GAME_START,
  output logic               RESPAWN_OUT
);
  localparam logic [TIMER_W-1:0] RESP_LAST = TIMER_W'(RESPAWN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_END  = TIMER_W'(END_HOLD_CYCLES);
  localparam logic [LIVES_W-1:0] LIVES_MAX = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] ONE_LIFE  = LIVES_W'(1);

  logic btn_rise;
  logic pause_rise;

  edge_detect #(.W(BTN_W)) u_btn_edge (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .d_i    (PUSH_BUTTONS),
    .rise_o (btn_rise)
  );

  edge_detect #(.W(1)) u_pause_edge (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .d_i    (PAUSE_BTN),
    .rise_o (pause_rise)
  );

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               start_q, start_d;
  logic               resp_q, resp_d;
  logic               won;

  assign won = 32'(SCORE_IN) >= WIN_SCORE;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      lives_q <= LIVES_MAX;
      start_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lives_q <= lives_d;
      start_q <= start_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lives_d = lives_q;
    start_d = 1'b0;
    resp_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_rise) begin
          state_d = S_PLAY;
          timer_d = '0;
          lives_d = LIVES_MAX;
          start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (won) begin
          state_d = S_WIN;
          timer_d = '0;
        end else if (SUICIDE_IN && lives_q == ONE_LIFE) begin
          state_d = S_LOSE;
          timer_d = '0;
          lives_d = '0;
        end else if (SUICIDE_IN) begin
          state_d = S_RESPAWN;
          timer_d = '0;
          lives_d = lives_q - ONE_LIFE;
          resp_d  = 1'b1;
        end else if (pause_rise) begin
          state_d = S_PAUSE;
          timer_d = '0;
        end
      end
      S_PAUSE: begin
        if (pause_rise) begin
          state_d = S_PLAY;
          timer_d = '0;
        end
      end
      S_RESPAWN: begin
        if (timer_q == RESP_LAST) begin
          state_d = S_PLAY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_WIN, S_LOSE: begin
        // Lockout: presses only count once the timer has saturated.
        if (timer_q < HOLD_END) begin
          timer_d = timer_q + TIMER_W'(1);
        end else if (btn_rise) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign STATE_OUT   = state_q;
  assign LIVES_OUT   = lives_q;
  assign GAME_START  = start_q;
  assign RESPAWN_OUT = resp_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with short respawn/hold timers.
module tb_game_flow_controller;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] PUSH_BUTTONS = '0;
  logic       PAUSE_BTN = 1'b0;
  logic [3:0] SCORE_IN = '0;
  logic       SUICIDE_IN = 1'b0;
  logic [2:0] STATE_OUT;
  logic [1:0] LIVES_OUT;
  logic       GAME_START;
  logic       RESPAWN_OUT;

  int n_chk  = 0;
  int n_fail = 0;

  game_flow_controller #(
    .WIN_SCORE       (10),
    .SCORE_W         (4),
    .BTN_W           (4),
    .LIVES           (3),
    .LIVES_W         (2),
    .RESPAWN_CYCLES  (4),
    .END_HOLD_CYCLES (8),
    .TIMER_W         (26)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .PUSH_BUTTONS (PUSH_BUTTONS),
    .PAUSE_BTN    (PAUSE_BTN),
    .SCORE_IN     (SCORE_IN),
    .SUICIDE_IN   (SUICIDE_IN),
    .STATE_OUT    (STATE_OUT),
    .LIVES_OUT    (LIVES_OUT),
    .GAME_START   (GAME_START),
    .RESPAWN_OUT  (RESPAWN_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic expect_out(string tag, int st, int lv, int gs, int rs);
    chk({tag, ".state"}, 32'(STATE_OUT), st);
    chk({tag, ".lives"}, 32'(LIVES_OUT), lv);
    chk({tag, ".start"}, 32'(GAME_START), gs);
    chk({tag, ".resp"}, 32'(RESPAWN_OUT), rs);
  endtask

  // Wait out the end-screen lockout, then press to go back to IDLE.
  task automatic end_to_idle(string tag, int lv);
    repeat (9) tick();
    PUSH_BUTTONS = 4'b0100;
    tick();
    expect_out(tag, 0, lv, 0, 0);
    PUSH_BUTTONS = '0;
    tick();
  endtask

  task automatic new_game(string tag);
    PUSH_BUTTONS = 4'b0001;
    tick();
    expect_out(tag, 1, 3, 1, 0);
    PUSH_BUTTONS = '0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    expect_out("rst", 0, 3, 0, 0);
    RESET = 1'b0;
    tick();
    expect_out("idle", 0, 3, 0, 0);

    // 1: start and hold
    PUSH_BUTTONS = 4'b0010;
    tick();
    expect_out("start", 1, 3, 1, 0);
    tick();
    expect_out("hold1", 1, 3, 0, 0);
    tick();
    expect_out("hold2", 1, 3, 0, 0);
    PUSH_BUTTONS = '0;
    SCORE_IN = 4'd9;
    tick();
    expect_out("score9", 1, 3, 0, 0);
    SCORE_IN = '0;

    // 2: respawn with suicide held
    SUICIDE_IN = 1'b1;
    tick();
    expect_out("resp", 5, 2, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("resp_w%0d", i), 5, 2, 0, 0);
    end
    SUICIDE_IN = 1'b0;
    tick();
    expect_out("resp_done", 1, 2, 0, 0);

    // 3: lose
    SUICIDE_IN = 1'b1;
    tick();
    expect_out("resp2", 5, 1, 0, 1);
    SUICIDE_IN = 1'b0;
    repeat (3) tick();
    chk("resp2_w", 32'(STATE_OUT), 5);
    tick();
    chk("resp2_done", 32'(STATE_OUT), 1);
    SUICIDE_IN = 1'b1;
    tick();
    expect_out("lose", 3, 0, 0, 0);
    SUICIDE_IN = 1'b0;
    repeat (4) tick();
    PUSH_BUTTONS = 4'b0010;
    tick();
    chk("lose_p5", 32'(STATE_OUT), 3);
    PUSH_BUTTONS = '0;
    tick();
    tick();
    PUSH_BUTTONS = 4'b0001;
    tick();
    chk("lose_p8", 32'(STATE_OUT), 3);
    PUSH_BUTTONS = 4'b0011;
    tick();
    expect_out("lose_idle", 0, 0, 0, 0);
    PUSH_BUTTONS = '0;
    tick();
    expect_out("idle_stay", 0, 0, 0, 0);
    new_game("g2");

    // 4: win beats suicide; score above threshold
    SCORE_IN = 4'd10;
    SUICIDE_IN = 1'b1;
    tick();
    expect_out("win10", 2, 3, 0, 0);
    SCORE_IN = '0;
    SUICIDE_IN = 1'b0;
    end_to_idle("win_idle", 3);
    new_game("g3");
    SCORE_IN = 4'd12;
    tick();
    expect_out("win12", 2, 3, 0, 0);
    SCORE_IN = '0;
    end_to_idle("win12_idle", 3);
    new_game("g4");

    // 5: pause
    PAUSE_BTN = 1'b1;
    tick();
    expect_out("pause", 4, 3, 0, 0);
    SUICIDE_IN = 1'b1;
    SCORE_IN = 4'd10;
    tick();
    expect_out("pause_ign", 4, 3, 0, 0);
    SUICIDE_IN = 1'b0;
    SCORE_IN = '0;
    PAUSE_BTN = 1'b0;
    tick();
    chk("pause_rel", 32'(STATE_OUT), 4);
    PAUSE_BTN = 1'b1;
    tick();
    chk("unpause", 32'(STATE_OUT), 1);
    PAUSE_BTN = 1'b0;
    tick();
    PAUSE_BTN = 1'b1;
    SUICIDE_IN = 1'b1;
    tick();
    expect_out("pause_vs_die", 5, 2, 0, 1);
    PAUSE_BTN = 1'b0;
    SUICIDE_IN = 1'b0;

    // 6: reset in RESPAWN with button held
    PUSH_BUTTONS = 4'b1000;
    RESET = 1'b1;
    tick();
    expect_out("rst_resp", 0, 3, 0, 0);
    RESET = 1'b0;
    tick();
    tick();
    expect_out("rst_resp_held", 0, 3, 0, 0);
    PUSH_BUTTONS = '0;
    tick();
    new_game("g5");
    SUICIDE_IN = 1'b1;
    tick();
    chk("g5_lives", 32'(LIVES_OUT), 2);
    SUICIDE_IN = 1'b0;
    repeat (4) tick();
    SCORE_IN = 4'd11;
    tick();
    expect_out("g5_win", 2, 2, 0, 0);
    SCORE_IN = '0;
    PUSH_BUTTONS = 4'b1000;
    RESET = 1'b1;
    tick();
    expect_out("rst_win", 0, 3, 0, 0);
    RESET = 1'b0;
    tick();
    tick();
    expect_out("rst_win_held", 0, 3, 0, 0);
    PUSH_BUTTONS = '0;
    tick();
    chk("rst_win_rel", 32'(STATE_OUT), 0);
    PUSH_BUTTONS = 4'b1000;
    tick();
    expect_out("repress", 1, 3, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
